tc_irq_ctrl: RTL
================

TC_IRQ_CTRL -- requirements
Module: tc_irq_ctrl

Interface
REQ-001 Parameter A_IMSK, 8'h6F, register address of the interrupt mask register.
REQ-002 Parameter A_IFLG, 8'h16, register address of the interrupt flag register.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 src_set  input  6  per-source event pulses: [0] TOV0, [1] OCFA0, [2] OCFB0, [3] TOV1, [4] OCFA1, [5] OCFB1.
REQ-006 addr  input  8  register address.
REQ-007 wdata  input  8  write data.
REQ-008 write  input  1  write strobe, one access per cycle.
REQ-009 read  input  1  read strobe.
REQ-010 rdata  output  8  read data.
REQ-011 interrupt_request  output  1  registered interrupt request to the CPU.
REQ-012 vector  output  3  index of the source being serviced.
REQ-013 interrupt_executed  input  1  CPU acknowledge of the current request.

Function
REQ-014 The IMSK register (RW) SHALL be laid out as: [5:0] per-source enable, [6] reads 0 and ignores writes, [7] GIE global enable.
REQ-015 The IFLG register SHALL be laid out as: [5:0] flags, [7:6] read 0; a write SHALL clear each flag whose wdata bit is 1 (write-1-to-clear), and writing 0 SHALL have no effect.
REQ-016 src_set[i] high in a cycle SHALL set flag i at the next edge; set SHALL win over a same-cycle W1C clear or acknowledge clear.
REQ-017 pending SHALL equal IFLG[5:0] & IMSK[5:0], qualified by IMSK[7].
REQ-018 rdata SHALL be combinational: register contents when read=1 and addr matches A_IMSK or A_IFLG, otherwise 8'h00.
REQ-019 The FSM SHALL have three states: IDLE, REQ and GAP.
REQ-020 IDLE: if pending is nonzero, the FSM SHALL latch the winning index into vector and move to REQ; interrupt_request SHALL be high from the next edge (one cycle from pending to request).
REQ-021 REQ: interrupt_request and vector SHALL hold stable; the request SHALL NOT be withdrawn on a mask change or a W1C write.
REQ-022 REQ with interrupt_executed=1: the FSM SHALL clear IFLG[vector] (subject to REQ-016), drop interrupt_request at the same edge and go to GAP.
REQ-023 GAP SHALL last exactly one cycle with interrupt_request low, then go to IDLE; back-to-back requests are therefore separated by at least one low cycle.
REQ-024 interrupt_executed SHALL be ignored in IDLE and GAP.
REQ-025 Default arbitration SHALL be fixed priority, with the lowest pending index winning.
REQ-026 vector SHALL retain its last value while interrupt_request is low.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set: IMSK=0, IFLG=0, state IDLE, interrupt_request=0, vector=0, round-robin pointer=5; src_set in that cycle SHALL be discarded.
REQ-028 rst asserted while in REQ SHALL drop interrupt_request at that edge without any acknowledge.

Configuration
REQ-029 With TC_IRQ_ROUND_ROBIN_EN defined, arbitration SHALL search from (last serviced index + 1) mod 6 upward with wrap-around, and the pointer SHALL update on acknowledge only.
REQ-030 Without TC_IRQ_ROUND_ROBIN_EN, arbitration SHALL be fixed priority per REQ-025, and no pointer register SHALL exist.

Verification
REQ-031 Scenario, basic service: write IMSK=8'h81, pulse src_set=6'h01 -> IFLG=8'h01 next cycle, interrupt_request high the cycle after with vector=0; ack -> IFLG=8'h00, request low.
REQ-032 Scenario, fixed priority: IMSK=8'hBF, src_set=6'h24 in one cycle -> vector=2 is served first, then after one GAP cycle vector=5.
REQ-033 Scenario, set wins: in REQ on vector=1, assert src_set[1] in the same cycle as interrupt_executed -> IFLG[1] remains 1 and a new request with vector=1 follows the GAP cycle.
REQ-034 Scenario, W1C and mask: set flags 6'h0A with IMSK=8'h0A (GIE=0) -> no request; read IFLG -> 8'h0A; write IFLG=8'h02 -> reads 8'h08.
REQ-035 Scenario, round-robin (macro defined): keep sources 0 and 1 continuously re-pulsed, IMSK=8'h83 -> vectors alternate 0,1,0,1.
REQ-036 Scenario, reset mid-request: assert rst during REQ -> interrupt_request=0, IMSK=8'h00, IFLG=8'h00 on the next cycle.

Source files
------------

// File: rtl/tc_irq_ctrl.sv
// tc_irq_ctrl: six-source timer interrupt controller with IMSK/IFLG registers and a request/acknowledge handshake.
// Define TC_IRQ_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module tc_irq_ctrl #(
  parameter logic [7:0] A_IMSK = 8'h6F,
  parameter logic [7:0] A_IFLG = 8'h16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] src_set,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       write,
  input  logic       read,
  output logic [7:0] rdata,
  output logic       interrupt_request,
  output logic [2:0] vector,
  input  logic       interrupt_executed
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e     state_q, state_d;
  logic [7:0] imsk_q, imsk_d;
  logic [5:0] iflg_q, iflg_d;
  logic       irq_q, irq_d;
  logic [2:0] vec_q, vec_d;
  logic [5:0] pending;
  logic [2:0] winner;

  assign pending = imsk_q[7] ? (iflg_q & imsk_q[5:0]) : 6'h00;

`ifdef TC_IRQ_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
  logic       ack;

  function automatic logic [2:0] wrap6(input logic [3:0] v);
    return (v >= 4'd6) ? 3'(v - 4'd6) : v[2:0];
  endfunction

  assign ack = (state_q == REQ) && interrupt_executed;

  // Walk from farthest to nearest so the first pending index after the pointer is kept.
  always_comb begin
    winner = 3'd0;
    for (int k = 6; k >= 1; k--) begin
      if (pending[wrap6({1'b0, ptr_q} + 4'(k))]) winner = wrap6({1'b0, ptr_q} + 4'(k));
    end
  end

  assign ptr_d = ack ? vec_q : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 3'd5;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    winner = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pending[i]) winner = 3'(i);
    end
  end
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    imsk_d  = imsk_q;
    iflg_d  = iflg_q;

    if (write && addr == A_IMSK) imsk_d = wdata & 8'hBF;
    if (write && addr == A_IFLG) iflg_d = iflg_d & ~wdata[5:0];

    case (state_q)
      IDLE: begin
        if (pending != 6'h00) begin
          vec_d   = winner;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (interrupt_executed) begin
          iflg_d[vec_q] = 1'b0;
          irq_d         = 1'b0;
          state_d       = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // New events are merged last so they override any clear in the same cycle.
    iflg_d = iflg_d | src_set;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; src_set and writes in the reset cycle are dropped.
    if (rst) begin
      state_q <= IDLE;
      imsk_q  <= 8'h00;
      iflg_q  <= 6'h00;
      irq_q   <= 1'b0;
      vec_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      imsk_q  <= imsk_d;
      iflg_q  <= iflg_d;
      irq_q   <= irq_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (read) begin
      if (addr == A_IMSK)      rdata = imsk_q;
      else if (addr == A_IFLG) rdata = {2'b00, iflg_q};
    end
  end

  assign interrupt_request = irq_q;
  assign vector            = vec_q;

endmodule
